// File: rtl/pwm_counter.sv
// Button-controlled PWM LED dimmer.
// Four debounced push-buttons adjust a duty level in percent. A free-running
// period counter is compared against the derived threshold to drive the LED.
module pwm_counter #(
  parameter int unsigned CYCLES_PER_PCT  = 1_000_000,
  parameter int unsigned STEP_PCT        = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RESET_PCT       = 50,
  parameter int unsigned PRESET_HI_PCT   = 70,
  parameter int unsigned PRESET_LO_PCT   = 20
) (
  input  logic        clk,
  input  logic        restart,
  input  logic        RightButton,
  input  logic        LeftButton,
  input  logic        SeventyF_button,
  input  logic        twentyF_button,
  output logic        led,
  output logic [26:0] duty_cycleMulti7
);

  localparam int unsigned NB = 4;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [26:0]   PERIOD_LAST = 27'(100 * CYCLES_PER_PCT - 1);
  localparam logic [26:0]   CPP         = 27'(CYCLES_PER_PCT);
  localparam logic [26:0]   THRESH_RST  = 27'(RESET_PCT * CYCLES_PER_PCT);
  localparam logic [6:0]    STEP        = 7'(STEP_PCT);
  localparam logic [6:0]    PCT_RST     = 7'(RESET_PCT);
  localparam logic [6:0]    PCT_HI      = 7'(PRESET_HI_PCT);
  localparam logic [6:0]    PCT_LO      = 7'(PRESET_LO_PCT);
  localparam logic [6:0]    PCT_MAX     = 7'd100;

  // Button bit order: 0 Right, 1 Left, 2 twenty preset, 3 seventy preset.
  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] stable;
  logic [NB-1:0] stable_d;
  logic [NB-1:0] press;
  logic [DW-1:0] db_cnt [NB];

  logic [6:0]  duty_pct;
  logic [6:0]  nxt_pct;
  logic [26:0] period_cnt;

  assign raw = {SeventyF_button, twentyF_button, LeftButton, RightButton};

  // Two-flop synchronizer for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the synchronized level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level
  // restarts the count (for a 1-bit signal this is "restart on any change").
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      stable <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the accepted level gives one press pulse per physical press.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      stable_d <= '0;
      press    <= '0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

  // Next duty level: presets outrank steps; opposing steps cancel.
  always_comb begin
    nxt_pct = duty_pct;
    if (press[3]) begin
      nxt_pct = PCT_HI;
    end else if (press[2]) begin
      nxt_pct = PCT_LO;
    end else if (press[0] && !press[1]) begin
      nxt_pct = (duty_pct >= PCT_MAX - STEP) ? PCT_MAX : duty_pct + STEP;
    end else if (press[1] && !press[0]) begin
      nxt_pct = (duty_pct <= STEP) ? '0 : duty_pct - STEP;
    end
  end

  // Duty level and its threshold are registered together.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      duty_pct         <= PCT_RST;
      duty_cycleMulti7 <= THRESH_RST;
    end else begin
      duty_pct         <= nxt_pct;
      duty_cycleMulti7 <= 27'(nxt_pct) * CPP;
    end
  end

  // Free-running period counter and registered PWM compare.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      period_cnt <= '0;
      led        <= 1'b0;
    end else begin
      period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
      led        <= (period_cnt < duty_cycleMulti7);
    end
  end

endmodule

// File: tb/tb_pwm_counter.sv
// Scoreboard bench for pwm_counter: stimulus pushes expected thresholds,
// a monitor pops and compares whenever duty_cycleMulti7 changes.
module tb_pwm_counter;

  logic        clk;
  logic        restart;
  logic [3:0]  btn;
  logic        led;
  logic [26:0] duty;

  int checks;
  int errors;
  int exp_q[$];
  int model_pct;

  pwm_counter #(
    .CYCLES_PER_PCT (10),
    .STEP_PCT       (10),
    .DEBOUNCE_CYCLES(4),
    .RESET_PCT      (50),
    .PRESET_HI_PCT  (70),
    .PRESET_LO_PCT  (20)
  ) dut (
    .clk             (clk),
    .restart         (restart),
    .RightButton     (btn[0]),
    .LeftButton      (btn[1]),
    .twentyF_button  (btn[2]),
    .SeventyF_button (btn[3]),
    .led             (led),
    .duty_cycleMulti7(duty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every change of the threshold outside reset must match the queue.
  initial begin : monitor
    logic [26:0] prev;
    int e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!restart) begin
        prev = duty;
      end else if (duty !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update: got %0d, required no change from %0d", duty, prev);
        end else begin
          e = exp_q.pop_front();
          if (duty !== 27'(e)) begin
            errors++;
            $display("FAIL threshold_update: got %0d, required %0d", duty, e);
          end
        end
        prev = duty;
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    restart = 1'b0;
    #3;
    check("reset_led", int'(led), 0);
    check("reset_threshold", int'(duty), 500);
    repeat (3) @(negedge clk);
    check("reset_hold_threshold", int'(duty), 500);
    restart = 1'b1;
    model_pct = 50;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    @(negedge clk);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (14) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic right_press();
    int nxt;
    nxt = (model_pct + 10 > 100) ? 100 : model_pct + 10;
    if (nxt != model_pct) exp_q.push_back(nxt * 10);
    model_pct = nxt;
    press(4'b0001, 12);
  endtask

  task automatic left_press();
    int nxt;
    nxt = (model_pct < 10) ? 0 : model_pct - 10;
    if (nxt != model_pct) exp_q.push_back(nxt * 10);
    model_pct = nxt;
    press(4'b0010, 12);
  endtask

  task automatic count_led(output int n);
    n = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      n += int'(led);
    end
  endtask

  initial begin : stim
    int n;
    checks    = 0;
    errors    = 0;
    btn       = '0;
    restart   = 1'b0;
    model_pct = 50;
    repeat (3) @(negedge clk);

    // 1. reset state and 50 % duty
    do_reset();
    count_led(n);
    check("led_50pct_count", n, 500);

    // 2. Right x6 saturates at 100 %
    for (int i = 0; i < 6; i++) right_press();
    drain("right_drain");
    check("right_saturate", int'(duty), 1000);
    count_led(n);
    check("led_100pct_count_a", n, 1000);
    count_led(n);
    check("led_100pct_count_b", n, 1000);

    // 3. Left x11 from reset floors at 0 %
    do_reset();
    for (int i = 0; i < 11; i++) left_press();
    drain("left_drain");
    check("left_floor", int'(duty), 0);
    count_led(n);
    check("led_0pct_count", n, 0);

    // 4. presets, sequential then simultaneous; opposing steps cancel
    do_reset();
    exp_q.push_back(700);
    press(4'b1000, 12);
    exp_q.push_back(200);
    press(4'b0100, 12);
    exp_q.push_back(700);
    press(4'b1100, 12);
    drain("preset_drain");
    press(4'b0011, 12);
    check("right_left_cancel", int'(duty), 700);

    // 5. hold Right for 5000 cycles: one step only
    do_reset();
    exp_q.push_back(600);
    press(4'b0001, 5000);
    drain("hold_drain");
    check("hold_single_step", int'(duty), 600);

    // 6. bouncing Right never accepted; restart mid-period
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); btn = 4'b0001;
      @(negedge clk);
      @(negedge clk); btn = '0;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("bounce_no_change", int'(duty), 600);
    check("bounce_queue_empty", exp_q.size(), 0);
    repeat (337) @(negedge clk);
    do_reset();
    count_led(n);
    check("led_after_restart", n, 500);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
